lc3_fetch_unit: RTL and testbench
=================================

// Module: lc3_fetch_unit
// PURPOSE
//  Instruction-fetch stage that sits directly upstream of decode. Owns the PC and
//  issues a memory read at PC when the controller asks for an instruction. Returns
//  the fetched word and its address, advances the PC, and accepts branch/jump/JSR
//  redirects from execute (F_Control path), including a redirect that lands mid-fetch.
// PARAMETERS
//  RESET_PC  16'h3000  PC value loaded on reset
//  MAX_WAIT  15        cycles in REQ without mem_rdy before fetch_err (1..255)
// PORTS
//  clock        in   1   global system clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  fetch_en     in   1   controller request for the next instruction (level, sampled in IDLE)
//  redirect     in   1   taken branch/JMP/JSR from execute; PC <= target_pc
//  target_pc    in   16  redirect target address
//  mem_rdy      in   1   memory read data valid this cycle
//  mem_rdata    in   16  memory read data
//  mem_req      out  1   read request; held high until mem_rdy
//  mem_addr     out  16  read address (= PC register)
//  instr        out  16  fetched instruction, feeds decode dout/IR path
//  instr_valid  out  1   one-cycle pulse: instr/pc/npc are new
//  pc           out  16  address of instr
//  npc          out  16  pc + 1 (mod 2^16), used by JSR/LEA/BR offset math
//  fetch_busy   out  1   high in REQ
//  fetch_err    out  1   sticky memory timeout flag
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, PC=RESET_PC, mem_req=0, instr=0, pc=0,
//   npc=0, instr_valid=0, fetch_err=0, squash=0, wait_cnt=0. mem_addr=RESET_PC.
//  All outputs are registered; mem_addr is driven continuously from the PC register.
//  States: IDLE, REQ, ERR.
//  IDLE: mem_req=0.
//   redirect=1 -> PC<=target_pc. If fetch_en=1 in the same cycle -> REQ, and the
//    fetch uses target_pc.
//   else fetch_en=1 -> REQ.
//  REQ: mem_req=1, mem_addr=PC; wait_cnt increments each cycle without mem_rdy.
//   mem_rdy=1, squash=0 -> instr<=mem_rdata, pc<=PC, npc<=PC+1, PC<=PC+1;
//    instr_valid=1 next cycle; -> IDLE. Single-cycle latency from mem_rdy to instr_valid.
//   redirect=1 while in REQ (mem_rdy=0) -> PC_pending<=target_pc, squash<=1.
//    The request is not dropped and mem_addr is unchanged until the handshake completes.
//   mem_rdy=1, squash=1 -> data discarded, no instr_valid; PC<=PC_pending, squash<=0.
//    Stay in REQ and reissue at the new PC next cycle; wait_cnt<=0.
//   redirect and mem_rdy in the same cycle -> completes as squashed (target wins).
//   Latest redirect wins if several arrive during one request.
//   wait_cnt reaches MAX_WAIT with mem_rdy=0 -> ERR.
//  ERR: mem_req=0, fetch_err=1. fetch_en and redirect are ignored. Exit only by reset.
//  Arithmetic: PC+1 is 16-bit, so 16'hFFFF wraps to 16'h0000; no flag is raised.
//  wait_cnt is 8 bits, cleared on every entry to REQ.
//  instr_valid is 0 in every cycle other than the pulse.
//  instr, pc and npc hold their values until the next valid fetch.
//  fetch_en held high across a completion: exactly one fetch per IDLE visit.
//   Back-to-back fetches therefore cost at least 2 cycles each.
// TESTING
//  1 reset; fetch_en=1; mem_rdy on the 1st REQ cycle, rdata=16'h1261
//    -> mem_addr=16'h3000; instr=16'h1261, pc=16'h3000, npc=16'h3001.
//    instr_valid pulses for exactly 1 cycle; PC=16'h3001.
//  2 PC=16'hFFFF, fetch with rdata=16'h5020
//    -> pc=16'hFFFF, npc=16'h0000; next mem_addr=16'h0000.
//  3 IDLE, redirect=1 with target_pc=16'h4000 and fetch_en=1 in the same cycle
//    -> next cycle mem_req=1, mem_addr=16'h4000.
//  4 In REQ at 16'h3005: redirect to 16'h3100, then mem_rdy 2 cycles later
//    -> no instr_valid; REQ reissued at 16'h3100.
//    mem_rdy there with rdata=16'h0E02 -> instr=16'h0E02, pc=16'h3100.
//  5 MAX_WAIT=15, mem_rdy held 0 -> fetch_err=1 and mem_req=0 after 15 REQ cycles.
//    Further fetch_en/redirect have no effect.
//    Async reset mid-REQ -> all outputs return to reset values without waiting for clock.

Source files
------------

// File: rtl/lc3_fetch_unit.sv
// rtl/lc3_fetch_unit.sv - LC-3 instruction fetch stage with PC, redirect squash and timeout
module lc3_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [15:0] target_pc,
    input  logic        mem_rdy,
    input  logic [15:0] mem_rdata,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] pc,
    output logic [15:0] npc,
    output logic        fetch_busy,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Last unready REQ cycle that is still tolerated before giving up.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] pc_reg;
    logic [15:0] pc_reg_next;
    logic [15:0] pc_pending;
    logic [15:0] pc_pending_next;
    logic        squash;
    logic        squash_next;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_next;
    logic [15:0] instr_next;
    logic [15:0] pc_next;
    logic [15:0] npc_next;
    logic        instr_valid_next;
    logic        mem_req_next;
    logic        fetch_err_next;

    // The read address always tracks the live PC; mem_req tells memory when it matters.
    assign mem_addr   = pc_reg;
    assign fetch_busy = mem_req;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // PC, squash bookkeeping and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_reg      <= RESET_PC;
            pc_pending  <= 16'h0000;
            squash      <= 1'b0;
            wait_cnt    <= 8'h00;
            instr       <= 16'h0000;
            pc          <= 16'h0000;
            npc         <= 16'h0000;
            instr_valid <= 1'b0;
            mem_req     <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            pc_reg      <= pc_reg_next;
            pc_pending  <= pc_pending_next;
            squash      <= squash_next;
            wait_cnt    <= wait_cnt_next;
            instr       <= instr_next;
            pc          <= pc_next;
            npc         <= npc_next;
            instr_valid <= instr_valid_next;
            mem_req     <= mem_req_next;
            fetch_err   <= fetch_err_next;
        end
    end

    // Next-state logic and next values of every register
    always_comb begin
        state_next       = state;
        pc_reg_next      = pc_reg;
        pc_pending_next  = pc_pending;
        squash_next      = squash;
        wait_cnt_next    = wait_cnt;
        instr_next       = instr;
        pc_next          = pc;
        npc_next         = npc;
        instr_valid_next = 1'b0;

        case (state)
            IDLE: begin
                // A redirect in IDLE lands directly in PC, so a same-cycle fetch uses it.
                if (redirect) begin
                    pc_reg_next = target_pc;
                end
                if (fetch_en) begin
                    state_next    = REQ;
                    wait_cnt_next = 8'h00;
                    squash_next   = 1'b0;
                end
            end
            REQ: begin
                if (mem_rdy) begin
                    wait_cnt_next = 8'h00;
                    if (redirect) begin
                        // Redirect racing the data: the returned word is stale, refetch at target.
                        pc_reg_next = target_pc;
                        squash_next = 1'b0;
                    end else if (squash) begin
                        pc_reg_next = pc_pending;
                        squash_next = 1'b0;
                    end else begin
                        instr_next       = mem_rdata;
                        pc_next          = pc_reg;
                        npc_next         = pc_reg + 16'h0001;
                        pc_reg_next      = pc_reg + 16'h0001;
                        instr_valid_next = 1'b1;
                        state_next       = IDLE;
                    end
                end else begin
                    // Keep the outstanding address stable; remember only the newest target.
                    if (redirect) begin
                        pc_pending_next = target_pc;
                        squash_next     = 1'b1;
                    end
                    wait_cnt_next = wait_cnt + 8'h01;
                    if (wait_cnt == WAIT_LAST) begin
                        state_next = ERR;
                    end
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        mem_req_next   = (state_next == REQ);
        fetch_err_next = (state_next == ERR);
    end

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// tb/tb_lc3_fetch_unit.sv - testbench for lc3_fetch_unit
module tb_lc3_fetch_unit;

    logic        clock;
    logic        reset;
    logic        fetch_en;
    logic        redirect;
    logic [15:0] target_pc;
    logic        mem_rdy;
    logic [15:0] mem_rdata;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic [15:0] npc;
    logic        fetch_busy;
    logic        fetch_err;

    int tests;
    int fails;

    lc3_fetch_unit #(.RESET_PC(16'h3000), .MAX_WAIT(15)) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .target_pc   (target_pc),
        .mem_rdy     (mem_rdy),
        .mem_rdata   (mem_rdata),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .npc         (npc),
        .fetch_busy  (fetch_busy),
        .fetch_err   (fetch_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        fe;
        logic        rd;
        logic [15:0] tgt;
        logic        rdy;
        logic [15:0] rdata;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
        logic [15:0] e_npc;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic fe, input logic rd, input logic [15:0] tgt,
                                input logic rdy, input logic [15:0] rdata,
                                input logic e_req, input logic [15:0] e_addr, input logic e_valid,
                                input logic [15:0] e_instr, input logic [15:0] e_pc,
                                input logic [15:0] e_npc);
        vec_t v;
        v.fe = fe; v.rd = rd; v.tgt = tgt; v.rdy = rdy; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_npc = e_npc;
        return v;
    endfunction

    task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a fetch transaction view of the unit.
    logic [15:0] m_pc;
    logic [15:0] m_target;
    logic        m_redirect_seen;
    logic        m_busy;
    logic        m_err;
    int          m_wait;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    logic [15:0] m_npc;
    logic        m_valid;

    task automatic model_reset();
        m_pc = 16'h3000; m_target = 16'h0000; m_redirect_seen = 1'b0;
        m_busy = 1'b0; m_err = 1'b0; m_wait = 0;
        m_instr = 16'h0000; m_ipc = 16'h0000; m_npc = 16'h0000; m_valid = 1'b0;
    endtask

    task automatic model_step();
        m_valid = 1'b0;
        if (m_err) begin
            // stuck until reset
        end else if (!m_busy) begin
            if (redirect) m_pc = target_pc;
            if (fetch_en) begin
                m_busy = 1'b1; m_wait = 0; m_redirect_seen = 1'b0;
            end
        end else if (mem_rdy) begin
            m_wait = 0;
            if (redirect) begin
                m_pc = target_pc; m_redirect_seen = 1'b0;
            end else if (m_redirect_seen) begin
                m_pc = m_target; m_redirect_seen = 1'b0;
            end else begin
                m_instr = mem_rdata; m_ipc = m_pc; m_npc = m_pc + 16'd1;
                m_pc = m_pc + 16'd1; m_valid = 1'b1; m_busy = 1'b0;
            end
        end else begin
            if (redirect) begin
                m_target = target_pc; m_redirect_seen = 1'b1;
            end
            m_wait++;
            if (m_wait >= 15) begin
                m_err = 1'b1; m_busy = 1'b0;
            end
        end
    endtask

    task automatic model_compare();
        chk1 ("rnd mem_req", mem_req, m_busy);
        chk16("rnd mem_addr", mem_addr, m_pc);
        chk1 ("rnd instr_valid", instr_valid, m_valid);
        chk16("rnd instr", instr, m_instr);
        chk16("rnd pc", pc, m_ipc);
        chk16("rnd npc", npc, m_npc);
        chk1 ("rnd fetch_busy", fetch_busy, m_busy);
        chk1 ("rnd fetch_err", fetch_err, m_err);
    endtask

    task automatic idle_inputs();
        fetch_en = 1'b0; redirect = 1'b0; target_pc = 16'h0000;
        mem_rdy = 1'b0; mem_rdata = 16'h0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk1 ({tag, " mem_req"}, mem_req, 1'b0);
        chk16({tag, " mem_addr"}, mem_addr, 16'h3000);
        chk16({tag, " instr"}, instr, 16'h0000);
        chk16({tag, " pc"}, pc, 16'h0000);
        chk16({tag, " npc"}, npc, 16'h0000);
        chk1 ({tag, " instr_valid"}, instr_valid, 1'b0);
        chk1 ({tag, " fetch_busy"}, fetch_busy, 1'b0);
        chk1 ({tag, " fetch_err"}, fetch_err, 1'b0);
    endtask

    initial begin
        tests = 0;
        fails = 0;

        //        fe  rd  tgt       rdy rdata     req addr      vld instr     pc        npc
        vecs[0]  = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h3000, 0, 16'h0000, 16'h0000, 16'h0000);
        vecs[1]  = mk(1, 0, 16'h0000, 1, 16'h1261, 0, 16'h3001, 1, 16'h1261, 16'h3000, 16'h3001);
        vecs[2]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h3001, 0, 16'h1261, 16'h3000, 16'h3001);
        vecs[3]  = mk(1, 1, 16'h4000, 0, 16'h0000, 1, 16'h4000, 0, 16'h1261, 16'h3000, 16'h3001);
        vecs[4]  = mk(0, 0, 16'h0000, 1, 16'h1234, 0, 16'h4001, 1, 16'h1234, 16'h4000, 16'h4001);
        vecs[5]  = mk(1, 1, 16'h3005, 0, 16'h0000, 1, 16'h3005, 0, 16'h1234, 16'h4000, 16'h4001);
        vecs[6]  = mk(0, 1, 16'h3100, 0, 16'h0000, 1, 16'h3005, 0, 16'h1234, 16'h4000, 16'h4001);
        vecs[7]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h3005, 0, 16'h1234, 16'h4000, 16'h4001);
        vecs[8]  = mk(0, 0, 16'h0000, 1, 16'hDEAD, 1, 16'h3100, 0, 16'h1234, 16'h4000, 16'h4001);
        vecs[9]  = mk(0, 0, 16'h0000, 1, 16'h0E02, 0, 16'h3101, 1, 16'h0E02, 16'h3100, 16'h3101);
        vecs[10] = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h3101, 0, 16'h0E02, 16'h3100, 16'h3101);
        vecs[11] = mk(0, 1, 16'h5000, 1, 16'hBEEF, 1, 16'h5000, 0, 16'h0E02, 16'h3100, 16'h3101);
        vecs[12] = mk(0, 0, 16'h0000, 1, 16'h0101, 0, 16'h5001, 1, 16'h0101, 16'h5000, 16'h5001);
        vecs[13] = mk(1, 1, 16'hFFFF, 0, 16'h0000, 1, 16'hFFFF, 0, 16'h0101, 16'h5000, 16'h5001);
        vecs[14] = mk(0, 0, 16'h0000, 1, 16'h5020, 0, 16'h0000, 1, 16'h5020, 16'hFFFF, 16'h0000);
        vecs[15] = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h5020, 16'hFFFF, 16'h0000);
        vecs[16] = mk(0, 1, 16'h6000, 0, 16'h0000, 1, 16'h0000, 0, 16'h5020, 16'hFFFF, 16'h0000);
        vecs[17] = mk(0, 1, 16'h7000, 0, 16'h0000, 1, 16'h0000, 0, 16'h5020, 16'hFFFF, 16'h0000);
        vecs[18] = mk(0, 0, 16'h0000, 1, 16'hAAAA, 1, 16'h7000, 0, 16'h5020, 16'hFFFF, 16'h0000);
        vecs[19] = mk(0, 0, 16'h0000, 1, 16'h1111, 0, 16'h7001, 1, 16'h1111, 16'h7000, 16'h7001);
        vecs[20] = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h7001, 0, 16'h1111, 16'h7000, 16'h7001);
        vecs[21] = mk(1, 0, 16'h0000, 1, 16'h2222, 0, 16'h7002, 1, 16'h2222, 16'h7001, 16'h7002);
        vecs[22] = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h7002, 0, 16'h2222, 16'h7001, 16'h7002);
        vecs[23] = mk(0, 0, 16'h0000, 1, 16'h3333, 0, 16'h7003, 1, 16'h3333, 16'h7002, 16'h7003);

        // Directed table
        do_reset();
        check_reset_values("reset");
        for (int i = 0; i < 24; i++) begin
            fetch_en  = vecs[i].fe;
            redirect  = vecs[i].rd;
            target_pc = vecs[i].tgt;
            mem_rdy   = vecs[i].rdy;
            mem_rdata = vecs[i].rdata;
            @(posedge clock);
            @(negedge clock);
            chk1 ($sformatf("vec%0d mem_req", i), mem_req, vecs[i].e_req);
            chk16($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_addr);
            chk1 ($sformatf("vec%0d instr_valid", i), instr_valid, vecs[i].e_valid);
            chk16($sformatf("vec%0d instr", i), instr, vecs[i].e_instr);
            chk16($sformatf("vec%0d pc", i), pc, vecs[i].e_pc);
            chk16($sformatf("vec%0d npc", i), npc, vecs[i].e_npc);
        end

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            model_compare();
            fetch_en  = ($urandom_range(0, 3) != 0);
            redirect  = ($urandom_range(0, 6) == 0);
            target_pc = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
            mem_rdy   = (m_wait >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
            @(posedge clock);
            model_step();
            @(negedge clock);
        end
        model_compare();

        // Timeout: 15 unready REQ cycles end in ERR
        do_reset();
        fetch_en = 1'b1;
        @(posedge clock);
        @(negedge clock);
        fetch_en = 1'b0;
        repeat (14) begin
            @(posedge clock);
            @(negedge clock);
        end
        chk1("timeout 14 mem_req", mem_req, 1'b1);
        chk1("timeout 14 fetch_err", fetch_err, 1'b0);
        @(posedge clock);
        @(negedge clock);
        chk1("timeout 15 mem_req", mem_req, 1'b0);
        chk1("timeout 15 fetch_err", fetch_err, 1'b1);
        chk1("timeout 15 fetch_busy", fetch_busy, 1'b0);

        // ERR ignores fetch_en and redirect
        fetch_en = 1'b1; redirect = 1'b1; target_pc = 16'h1234;
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
            chk1 ("err fetch_err", fetch_err, 1'b1);
            chk1 ("err mem_req", mem_req, 1'b0);
            chk16("err mem_addr", mem_addr, 16'h3000);
            chk1 ("err instr_valid", instr_valid, 1'b0);
        end
        idle_inputs();

        // Async reset from ERR, between clock edges
        #2 reset = 1'b1;
        #1 chk1("async err fetch_err", fetch_err, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Complete one fetch, start another, then reset mid-REQ
        fetch_en = 1'b1;
        @(posedge clock);
        @(negedge clock);
        fetch_en = 1'b0; mem_rdy = 1'b1; mem_rdata = 16'hABCD;
        @(posedge clock);
        @(negedge clock);
        chk16("pre-reset instr", instr, 16'hABCD);
        chk1 ("pre-reset instr_valid", instr_valid, 1'b1);
        mem_rdy = 1'b0; fetch_en = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk1 ("pre-reset mem_req", mem_req, 1'b1);
        chk16("pre-reset mem_addr", mem_addr, 16'h3001);
        fetch_en = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_values("async req");
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
